uart_tx_scheduler: RTL and testbench

- Shares one serial transmitter (TransEn / DataToTrans / sent interface, 16x oversampled, about 161 clk16x cycles per frame) between N_REQ byte producers.
- Arbitration is round-robin. A requester can lock the transmitter for a multi-byte packet using req_last.
- Generates the rising-edge TransEn pulse the transmitter needs, waits for sent, and enforces the inter-frame gap.
- Includes a watchdog so a missing sent cannot hang the system.

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_scheduler.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t      : scheduler FSM states
//   FRAME_CYCLES : nominal clk16x cycles per transmitted frame
//   TIMER_W      : width of the watchdog / gap timer
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_SEND,
        S_GAP
    } state_t;

    localparam int FRAME_CYCLES = 161;
    localparam int TIMER_W      = 9;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: returns the first requester with req set, scanning
// upward from rr_ptr and wrapping modulo N_REQ. Purely combinational.
//   req     : request vector
//   rr_ptr  : index with highest priority this round
//   grant   : selected requester index (0 when any_req is low)
//   any_req : at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [$clog2(N_REQ)-1:0] grant,
    output logic                     any_req
);

    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 16x-oversampled serial transmitter between N_REQ byte producers.
// Round-robin arbitration with optional packet lock (req_last=0 keeps the
// grant), TransEn edge generation, inter-frame gap and a watchdog.
//   clk16x      : transmit clock (16 x baud)
//   rst_n       : asynchronous active-low reset
//   req_valid   : per-requester byte valid
//   req_data    : byte of requester i at [8i+7:8i]
//   req_last    : byte ends its packet (releases the lock)
//   req_ready   : one-hot accept, transfer on valid & ready
//   tx_en       : transmitter TransEn
//   tx_data     : transmitter DataToTrans
//   tx_sent     : transmitter sent level
//   grant_id    : current or last granted requester
//   busy        : scheduler not idle
//   timeout_err : one-cycle pulse when the watchdog expires
//   frame_cnt   : frames completed (wraps)
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk16x,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    input  logic                     tx_sent,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     timeout_err,
    output logic [15:0]              frame_cnt
);

    localparam int ID_W = $clog2(N_REQ);
    localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] GAP_T     = TIMER_W'(GAP);
    localparam logic [TIMER_W-1:0] GAP_M1    = TIMER_W'(GAP - 1);

    state_t             state, state_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic               lock, lock_nxt;
    logic [ID_W-1:0]    rr_ptr, rr_ptr_nxt;
    logic [ID_W-1:0]    grant_nxt;
    logic [7:0]         data_nxt;
    logic [15:0]        cnt_nxt;
    logic               terr_nxt;
    logic [ID_W-1:0]    arb_grant;
    logic               arb_any;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    always_ff @(posedge clk16x or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            lock        <= 1'b0;
            rr_ptr      <= '0;
            grant_id    <= '0;
            tx_data     <= '0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            lock        <= lock_nxt;
            rr_ptr      <= rr_ptr_nxt;
            grant_id    <= grant_nxt;
            tx_data     <= data_nxt;
            frame_cnt   <= cnt_nxt;
            timeout_err <= terr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        lock_nxt   = lock;
        rr_ptr_nxt = rr_ptr;
        grant_nxt  = grant_id;
        data_nxt   = tx_data;
        cnt_nxt    = frame_cnt;
        terr_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                timer_nxt = '0;
                if (arb_any) begin
                    grant_nxt = arb_grant;
                    state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (req_valid[grant_id]) begin
                    data_nxt  = req_data[{grant_id, 3'b000} +: 8];
                    lock_nxt  = ~req_last[grant_id];
                    timer_nxt = '0;
                    state_nxt = S_SEND;
                end else if (!lock) begin
                    state_nxt = S_IDLE;
                end else if (timer == TIMEOUT_T) begin
                    // Locked requester went silent: drop the lock and move on.
                    terr_nxt   = 1'b1;
                    lock_nxt   = 1'b0;
                    rr_ptr_nxt = next_id(grant_id);
                    timer_nxt  = '0;
                    state_nxt  = S_IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_SEND: begin
                if (tx_sent) begin
                    cnt_nxt   = frame_cnt + 16'd1;
                    timer_nxt = '0;
                    state_nxt = S_GAP;
                end else if (timer == TIMEOUT_T) begin
                    // No sent from the transmitter: abandon the frame and the
                    // packet so GAP falls through to a fresh arbitration.
                    terr_nxt  = 1'b1;
                    lock_nxt  = 1'b0;
                    timer_nxt = '0;
                    state_nxt = S_GAP;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_GAP: begin
                // tx_sent is a level that may persist after the frame; wait for
                // it to clear so the next frame starts from a clean handshake.
                if (timer >= GAP_M1 && !tx_sent) begin
                    timer_nxt = '0;
                    if (lock) begin
                        state_nxt = S_ARB;
                    end else begin
                        rr_ptr_nxt = next_id(grant_id);
                        state_nxt  = S_IDLE;
                    end
                end else if (timer < GAP_T) begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == S_ARB) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign tx_en = (state == S_SEND);
    assign busy  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
    import uart_pkg::FRAME_CYCLES;

    localparam int N     = 4;
    localparam int GAP_P = 2;
    localparam int TO    = 255;

    logic             clk16x = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic             tx_en;
    logic [7:0]       tx_data;
    logic             tx_sent = 1'b0;
    logic [1:0]       grant_id;
    logic             busy;
    logic             timeout_err;
    logic [15:0]      frame_cnt;

    uart_tx_scheduler #(.N_REQ(N), .GAP(GAP_P), .TIMEOUT(TO)) dut (
        .clk16x      (clk16x),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_sent     (tx_sent),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk16x = ~clk16x;

    int total = 0;
    int bad   = 0;

    // producer byte queues {last, data}, and the model's copy
    logic [8:0] q  [N][$];
    logic [8:0] mq [N][$];
    int         model_ptr = 0;
    int         exp_id_q[$];
    logic [7:0] exp_data_q[$];

    // observations
    int         acc_id_q[$];
    logic [7:0] frames_q[$];
    int         en_len_q[$];
    int         cyc = 0;
    int         ready_cycles[N];
    int         valid_rise_cyc[N];
    int         rise_cyc, first_fall_cyc, terr_cyc;
    int         terr_cnt, unstable, min_gap, low_cnt, hi_len;
    bit         seen_fall, prev_en;
    logic [7:0] cur_data;
    logic [N-1:0] hs = '0;

    // transmitter model controls
    bit sent_on = 1'b1;
    int sent_hold = 0;
    int hold_left = 0;
    int en_cnt = 0;

    initial begin : env
        forever begin
            @(negedge clk16x);
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && q[i].size() > 0) begin
                    acc_id_q.push_back(i);
                    void'(q[i].pop_front());
                end
            end
            if (tx_en === 1'b1) begin
                en_cnt++;
                if (sent_on && en_cnt >= FRAME_CYCLES && !tx_sent) begin
                    tx_sent = 1'b1;
                    hold_left = sent_hold;
                end
            end else begin
                en_cnt = 0;
                if (tx_sent) begin
                    if (hold_left == 0) tx_sent = 1'b0;
                    else hold_left--;
                end
            end
            if (tx_en === 1'b1 && !prev_en) begin
                frames_q.push_back(tx_data);
                if (seen_fall && low_cnt < min_gap) min_gap = low_cnt;
                rise_cyc = cyc;
                cur_data = tx_data;
                hi_len = 0;
            end
            if (tx_en === 1'b1) begin
                hi_len++;
                if (tx_data !== cur_data) unstable++;
            end else begin
                if (prev_en) begin
                    en_len_q.push_back(hi_len);
                    if (first_fall_cyc < 0) first_fall_cyc = cyc;
                    seen_fall = 1'b1;
                    low_cnt = 0;
                end
                low_cnt++;
            end
            prev_en = (tx_en === 1'b1);
            if (timeout_err === 1'b1) begin
                terr_cnt++;
                if (terr_cyc < 0) terr_cyc = cyc;
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] === 1'b1) ready_cycles[i]++;
                if (q[i].size() > 0) begin
                    if (!req_valid[i]) valid_rise_cyc[i] = cyc;
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = q[i][0][7:0];
                    req_last[i] = q[i][0][8];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i] = 1'b0;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            hs = req_valid & req_ready;
        end
    end

    initial begin : global_limit
        #600000;
        $display("FAIL global_timeout: simulation did not end, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk16x);
        #1;
    endtask

    task automatic clear_stats();
        acc_id_q.delete(); frames_q.delete(); en_len_q.delete();
        exp_id_q.delete(); exp_data_q.delete();
        terr_cnt = 0; unstable = 0; min_gap = 1000000; seen_fall = 1'b0;
        rise_cyc = -1; first_fall_cyc = -1; terr_cyc = -1;
        for (int i = 0; i < N; i++) begin
            ready_cycles[i] = 0;
            valid_rise_cyc[i] = -1;
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            mq[i].delete();
        end
    endtask

    task automatic push_byte(input int id, input logic [7:0] d, input logic last);
        q[id].push_back({last, d});
        mq[id].push_back({last, d});
    endtask

    // Reference: serve whole packets round-robin over non-empty producers.
    // A packet ends at its last byte, or when the producer runs dry (the
    // lock watchdog then releases it); the pointer moves past the winner.
    task automatic model_run();
        int id;
        logic [8:0] b;
        while (1) begin
            id = -1;
            for (int k = 0; k < N; k++) begin
                if (id < 0 && mq[(model_ptr + k) % N].size() > 0) id = (model_ptr + k) % N;
            end
            if (id < 0) break;
            do begin
                b = mq[id].pop_front();
                exp_id_q.push_back(id);
                exp_data_q.push_back(b[7:0]);
            end while (!b[8] && mq[id].size() > 0);
            model_ptr = (id + 1) % N;
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int stream_diffs();
        int d = 0;
        if (acc_id_q.size() != exp_id_q.size()) d++;
        if (frames_q.size() != exp_data_q.size()) d++;
        for (int k = 0; k < exp_id_q.size(); k++) begin
            if (k >= acc_id_q.size() || acc_id_q[k] != exp_id_q[k]) d++;
            if (k >= frames_q.size() || frames_q[k] !== exp_data_q[k]) d++;
        end
        return d;
    endfunction

    task automatic wait_idle(input int budget, output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (busy === 1'b0 && all_empty()) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_queues();
        sent_on = 1'b1;
        sent_hold = 0;
        tick(); tick();
        rst_n = 1'b1;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_queues();
        tick(); tick();
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
        rst_n = 1'b1;
        model_ptr = 0;
        tick(); tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_release: busy got %b want 0", busy); end
    endtask

    task automatic test_single_byte();
        bit ok;
        int d;
        clear_stats();
        push_byte(2, 8'hA5, 1'b1);
        model_run();
        wait_idle(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done: idle reached %b want 1", ok); end
        total++; if (ready_cycles[2] !== 1) begin bad++; $display("FAIL single_ready_len: got %0d want 1", ready_cycles[2]); end
        total++; if (rise_cyc - valid_rise_cyc[2] !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", rise_cyc - valid_rise_cyc[2]); end
        total++; if (frames_q.size() != 1 || frames_q[0] !== 8'hA5 || unstable != 0) begin bad++; $display("FAIL single_data: frames %0d unstable %0d want 1 frame of a5 stable", frames_q.size(), unstable); end
        total++; if (en_len_q.size() != 1 || en_len_q[0] != FRAME_CYCLES) begin bad++; $display("FAIL single_tx_en_len: got %0d want %0d", (en_len_q.size() > 0) ? en_len_q[0] : -1, FRAME_CYCLES); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
        d = stream_diffs();
        total++; if (d != 0) begin bad++; $display("FAIL single_stream: diffs %0d want 0", d); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int d;
        do_reset();
        clear_stats();
        for (int i = 0; i < N; i++) push_byte(i, 8'($urandom), 1'b1);
        push_byte(0, 8'($urandom), 1'b1);
        model_run();
        wait_idle(5000, ok);
        d = stream_diffs();
        total++; if (!ok) begin bad++; $display("FAIL rr_done: idle reached %b want 1", ok); end
        total++; if (d != 0) begin bad++; $display("FAIL rr_order: diffs %0d want 0 (grants %0d want %0d)", d, acc_id_q.size(), exp_id_q.size()); end
        total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL rr_frame_cnt: got %0d want 5", frame_cnt); end
        total++; if (min_gap < GAP_P) begin bad++; $display("FAIL rr_gap: got %0d want >= %0d", min_gap, GAP_P); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rr_last_grant: got %0d want 0", grant_id); end
    endtask

    task automatic test_packet_lock();
        bit ok;
        int d;
        logic [15:0] fc0;
        clear_stats();
        fc0 = frame_cnt;
        push_byte(1, 8'($urandom), 1'b0);
        push_byte(1, 8'($urandom), 1'b0);
        push_byte(1, 8'($urandom), 1'b1);
        push_byte(3, 8'($urandom), 1'b1);
        model_run();
        wait_idle(5000, ok);
        d = stream_diffs();
        total++; if (!ok) begin bad++; $display("FAIL lock_done: idle reached %b want 1", ok); end
        total++; if (d != 0) begin bad++; $display("FAIL lock_order: diffs %0d want 0", d); end
        total++; if (frame_cnt !== 16'(fc0 + 16'd4)) begin bad++; $display("FAIL lock_frame_cnt: got %0d want %0d", frame_cnt, fc0 + 16'd4); end
        total++; if (ready_cycles[3] !== 1) begin bad++; $display("FAIL lock_other_grants: got %0d want 1", ready_cycles[3]); end
        total++; if (min_gap < GAP_P || unstable != 0) begin bad++; $display("FAIL lock_gap: gap %0d unstable %0d want >= %0d and 0", min_gap, unstable, GAP_P); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d, nb, len;
        logic [15:0] fc0;
        for (int r = 0; r < 3; r++) begin
            clear_stats();
            fc0 = frame_cnt;
            sent_hold = $urandom_range(0, 3);
            nb = 0;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        push_byte(i, 8'($urandom), b == len - 1);
                        nb++;
                    end
                end
            end
            if (nb == 0) begin
                push_byte($urandom_range(0, N - 1), 8'($urandom), 1'b1);
                nb = 1;
            end
            model_run();
            wait_idle(6000, ok);
            d = stream_diffs();
            total++; if (!ok) begin bad++; $display("FAIL b2b_done round %0d: idle reached %b want 1", r, ok); end
            total++; if (d != 0) begin bad++; $display("FAIL b2b_stream round %0d: diffs %0d want 0", r, d); end
            total++; if (frame_cnt !== 16'(fc0 + 16'(nb))) begin bad++; $display("FAIL b2b_frame_cnt round %0d: got %0d want %0d", r, frame_cnt, fc0 + 16'(nb)); end
            total++; if (min_gap < GAP_P || unstable != 0 || terr_cnt != 0) begin bad++; $display("FAIL b2b_timing round %0d: gap %0d unstable %0d terr %0d", r, min_gap, unstable, terr_cnt); end
        end
        sent_hold = 0;
    endtask

    task automatic test_send_watchdog();
        bit ok, seen;
        int d;
        do_reset();
        clear_stats();
        sent_on = 1'b0;
        push_byte(1, 8'($urandom), 1'b1);
        push_byte(2, 8'($urandom), 1'b1);
        model_run();
        seen = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (terr_cnt > 0) begin seen = 1'b1; break; end
        end
        sent_on = 1'b1;
        total++; if (!seen) begin bad++; $display("FAIL swd_seen: timeout_err seen %b want 1", seen); end
        wait_idle(2000, ok);
        d = stream_diffs();
        total++; if (!ok) begin bad++; $display("FAIL swd_done: idle reached %b want 1", ok); end
        total++; if (terr_cnt !== 1) begin bad++; $display("FAIL swd_pulses: got %0d want 1", terr_cnt); end
        total++; if (en_len_q.size() == 0 || en_len_q[0] != TO + 1) begin bad++; $display("FAIL swd_tx_en_len: got %0d want %0d", (en_len_q.size() > 0) ? en_len_q[0] : -1, TO + 1); end
        total++; if (terr_cyc != first_fall_cyc) begin bad++; $display("FAIL swd_pulse_time: got %0d want %0d", terr_cyc, first_fall_cyc); end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL swd_frame_cnt: got %0d want 1", frame_cnt); end
        total++; if (d != 0) begin bad++; $display("FAIL swd_next_served: diffs %0d want 0", d); end
    endtask

    task automatic test_lock_watchdog();
        bit ok;
        int d;
        do_reset();
        clear_stats();
        push_byte(0, 8'($urandom), 1'b0);
        push_byte(1, 8'($urandom), 1'b1);
        model_run();
        wait_idle(3000, ok);
        d = stream_diffs();
        total++; if (!ok) begin bad++; $display("FAIL lwd_done: idle reached %b want 1", ok); end
        total++; if (terr_cnt !== 1) begin bad++; $display("FAIL lwd_pulses: got %0d want 1", terr_cnt); end
        total++; if (ready_cycles[0] !== TO + 2) begin bad++; $display("FAIL lwd_arb_cycles: got %0d want %0d", ready_cycles[0], TO + 2); end
        total++; if (ready_cycles[1] !== 1 || grant_id !== 2'd1) begin bad++; $display("FAIL lwd_next_grant: ready %0d grant %0d want 1 and 1", ready_cycles[1], grant_id); end
        total++; if (d != 0) begin bad++; $display("FAIL lwd_stream: diffs %0d want 0", d); end
        total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL lwd_frame_cnt: got %0d want 2", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        bit ok, reached;
        int d;
        clear_stats();
        push_byte(2, 8'($urandom), 1'b1);
        model_run();
        reached = 1'b0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (tx_en === 1'b1 && hi_len == 80) begin reached = 1'b1; break; end
        end
        total++; if (!reached) begin bad++; $display("FAIL mid_reach: send cycle 80 reached %b want 1", reached); end
        rst_n = 1'b0;
        #1;
        total++; if (tx_en !== 1'b0 || req_ready !== 4'b0) begin bad++; $display("FAIL mid_outputs: tx_en %b ready %b want 0 and 0000", tx_en, req_ready); end
        total++; if (frame_cnt !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL mid_state: frame_cnt %0d busy %b want 0 and 0", frame_cnt, busy); end
        clear_queues();
        tick(); tick();
        rst_n = 1'b1;
        model_ptr = 0;
        tick();
        clear_stats();
        push_byte(3, 8'($urandom), 1'b1);
        push_byte(2, 8'($urandom), 1'b1);
        push_byte(0, 8'($urandom), 1'b1);
        model_run();
        wait_idle(3000, ok);
        d = stream_diffs();
        total++; if (!ok || d != 0) begin bad++; $display("FAIL mid_restart: idle %b diffs %0d want 1 and 0", ok, d); end
        total++; if (acc_id_q.size() == 0 || acc_id_q[0] != 0) begin bad++; $display("FAIL mid_first_grant: got %0d want 0", (acc_id_q.size() > 0) ? acc_id_q[0] : -1); end
        total++; if (frame_cnt !== 16'd3) begin bad++; $display("FAIL mid_frame_cnt: got %0d want 3", frame_cnt); end
    endtask

    initial begin : main
        clear_stats();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_back_to_back();
        test_send_watchdog();
        test_lock_watchdog();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
